// File: rtl/conv_encoder_framer_pkg.sv
// Shared constants and types for the rate-1/2, K=3 convolutional encoder framer.
// The generator defaults here are the same ones the Viterbi decoder's branch-metric
// tracker uses, so encoder and decoder cannot drift apart.
package conv_encoder_framer_pkg;

    localparam int unsigned K        = 3;
    localparam int unsigned TAIL_LEN = K - 1;

    localparam logic [2:0] G0_DEF = 3'b111;
    localparam logic [2:0] G1_DEF = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        TAIL
    } enc_fsm_t;

    // Parity of one generator over the tap vector {u, s[0], s[1]}.
    function automatic logic gen_parity(logic [2:0] g, logic u, logic [1:0] s);
        return ^(g & {u, s[0], s[1]});
    endfunction

endpackage

// File: rtl/conv_encoder_framer_if.sv
// Byte-in / symbol-out stream bundle for the convolutional encoder framer.
//   in_data/in_valid/in_ready            : payload byte stream into the encoder
//   out_sym/out_valid/out_ready          : encoded 2-bit symbol stream out
//   frame_start/frame_end                : markers on first payload / last tail symbol
// master: the environment (byte source and symbol sink); slave: the encoder.
interface conv_encoder_framer_if;

    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] out_sym;
    logic       out_valid;
    logic       out_ready;
    logic       frame_start;
    logic       frame_end;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_sym, out_valid, frame_start, frame_end
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_sym, out_valid, frame_start, frame_end
    );

endinterface

// File: rtl/conv_enc_core.sv
// Combinational trellis step of the K=3 convolutional code.
//   u      : input bit
//   s      : encoder state, s[0] previous bit, s[1] the bit before it
//   sym    : {g0_bit, g1_bit}
//   s_next : state after consuming u
module conv_enc_core
    import conv_encoder_framer_pkg::*;
#(
    parameter logic [2:0] G0 = G0_DEF,
    parameter logic [2:0] G1 = G1_DEF
) (
    input  logic       u,
    input  logic [1:0] s,
    output logic [1:0] sym,
    output logic [1:0] s_next
);

    always_comb begin
        sym    = {gen_parity(G0, u, s), gen_parity(G1, u, s)};
        s_next = {s[0], u};
    end

endmodule

// File: rtl/conv_encoder_framer.sv
// Rate-1/2, K=3 convolutional encoder with framing. Accepts FRAME_BYTES payload
// bytes, serialises them LSB-first, encodes each bit, then appends TAIL_LEN zero
// bits so the decoder trellis terminates in state 0.
//   clk, reset : symbol clock, asynchronous active-low reset
//   bus        : byte-in / symbol-out stream (slave side)
//   busy       : high whenever the FSM is not idle
module conv_encoder_framer
    import conv_encoder_framer_pkg::*;
#(
    parameter int unsigned FRAME_BYTES = 4,
    parameter logic [2:0]  G0          = G0_DEF,
    parameter logic [2:0]  G1          = G1_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    conv_encoder_framer_if.slave   bus,
    output logic                   busy
);

    localparam logic [7:0] LastByte = 8'(FRAME_BYTES);

    enc_fsm_t   state_q, state_d;
    logic [7:0] hold_q, hold_d;
    logic       hold_full_q, hold_full_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [7:0] bytes_cnt_q, bytes_cnt_d;
    logic       tail_cnt_q, tail_cnt_d;
    logic [1:0] s_q, s_d;
    logic       first_q, first_d;

    logic       u;
    logic [1:0] sym;
    logic [1:0] s_next;
    logic       in_ready;
    logic       out_valid;
    logic       frame_end;
    logic       in_hs;
    logic       out_hs;
    logic       bytes_left;
    logic       last_bit;

    conv_enc_core #(
        .G0 (G0),
        .G1 (G1)
    ) u_core (
        .u      (u),
        .s      (s_q),
        .sym    (sym),
        .s_next (s_next)
    );

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        bit_idx_d   = bit_idx_q;
        bytes_cnt_d = bytes_cnt_q;
        tail_cnt_d  = tail_cnt_q;
        s_d         = s_q;
        first_d     = first_q;
        u           = 1'b0;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        frame_end   = 1'b0;
        bytes_left  = bytes_cnt_q < LastByte;
        last_bit    = bit_idx_q == 3'd7;

        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
            end
            DATA: begin
                u         = hold_q[bit_idx_q];
                out_valid = hold_full_q;
                // Refill either into an empty hold register or in the same cycle the
                // last bit drains, so consecutive bytes stream without a bubble.
                in_ready  = bytes_left &
                            (~hold_full_q | (hold_full_q & last_bit & bus.out_ready));
            end
            TAIL: begin
                out_valid = 1'b1;
                frame_end = tail_cnt_q == 1'(TAIL_LEN - 1);
            end
            default: ;
        endcase

        // Nothing may be accepted while the block is held in reset.
        in_ready = in_ready & reset;
        in_hs    = bus.in_valid & in_ready;
        out_hs   = out_valid & bus.out_ready;

        unique case (state_q)
            IDLE: begin
                if (in_hs) begin
                    state_d     = DATA;
                    hold_d      = bus.in_data;
                    hold_full_d = 1'b1;
                    bytes_cnt_d = 8'd1;
                    bit_idx_d   = 3'd0;
                    s_d         = 2'b00;
                    first_d     = 1'b1;
                end
            end
            DATA: begin
                if (out_hs) begin
                    s_d       = s_next;
                    bit_idx_d = bit_idx_q + 3'd1;
                    first_d   = 1'b0;
                    if (last_bit) begin
                        hold_full_d = 1'b0;
                        if (!bytes_left) begin
                            state_d    = TAIL;
                            tail_cnt_d = 1'b0;
                        end
                    end
                end
                if (in_hs) begin
                    hold_d      = bus.in_data;
                    hold_full_d = 1'b1;
                    bytes_cnt_d = bytes_cnt_q + 8'd1;
                end
            end
            TAIL: begin
                if (out_hs) begin
                    s_d        = s_next;
                    tail_cnt_d = tail_cnt_q + 1'b1;
                    if (frame_end) begin
                        state_d     = IDLE;
                        bytes_cnt_d = 8'd0;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            hold_q      <= 8'd0;
            hold_full_q <= 1'b0;
            bit_idx_q   <= 3'd0;
            bytes_cnt_q <= 8'd0;
            tail_cnt_q  <= 1'b0;
            s_q         <= 2'b00;
            first_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            bit_idx_q   <= bit_idx_d;
            bytes_cnt_q <= bytes_cnt_d;
            tail_cnt_q  <= tail_cnt_d;
            s_q         <= s_d;
            first_q     <= first_d;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid;
    // Gated so the symbol lines read 0 whenever nothing is offered.
    assign bus.out_sym     = out_valid ? sym : 2'b00;
    assign bus.frame_start = first_q & out_valid;
    assign bus.frame_end   = frame_end;
    assign busy            = state_q != IDLE;

endmodule

// File: tb/tb_conv_encoder_framer.sv
// Self-checking bench: two encoders (FRAME_BYTES 1 and 2) share one stimulus path,
// selected by sel; every captured symbol is compared against a convolution model.
module tb_conv_encoder_framer;

    typedef struct packed {
        logic [1:0] sym;
        logic       fs;
        logic       fe;
    } sym_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       out_ready;
    logic       sel;
    logic       busy1, busy2;
    int         rdy_mode;
    int         n_checks = 0;
    int         n_fail = 0;
    int         gap_cycles = 0;

    sym_t       rx_q[$];
    sym_t       exp_q[$];

    conv_encoder_framer_if bus1 ();
    conv_encoder_framer_if bus2 ();

    assign bus1.in_data   = in_data;
    assign bus1.in_valid  = in_valid & ~sel;
    assign bus1.out_ready = out_ready;
    assign bus2.in_data   = in_data;
    assign bus2.in_valid  = in_valid & sel;
    assign bus2.out_ready = out_ready;

    conv_encoder_framer #(.FRAME_BYTES(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1),
        .busy  (busy1)
    );

    conv_encoder_framer #(.FRAME_BYTES(2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2),
        .busy  (busy2)
    );

    logic       obs_ready, obs_valid, obs_start, obs_end, obs_busy;
    logic [1:0] obs_sym;

    always_comb begin
        obs_ready = sel ? bus2.in_ready    : bus1.in_ready;
        obs_valid = sel ? bus2.out_valid   : bus1.out_valid;
        obs_start = sel ? bus2.frame_start : bus1.frame_start;
        obs_end   = sel ? bus2.frame_end   : bus1.frame_end;
        obs_sym   = sel ? bus2.out_sym     : bus1.out_sym;
        obs_busy  = sel ? busy2            : busy1;
    end

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference: each output bit is the mod-2 convolution of the bit stream
    // (payload LSB-first plus two zero tail bits) with the generator taps.
    function automatic void encode(input logic [7:0] bytes[$], output sym_t syms[$]);
        bit         b[$];
        logic [2:0] g0p;
        logic [2:0] g1p;
        logic       g0, g1, x;
        sym_t       e;
        g0p  = 3'o7;
        g1p  = 3'o5;
        syms = {};
        foreach (bytes[i]) for (int j = 0; j < 8; j++) b.push_back(bytes[i][j]);
        b.push_back(1'b0);
        b.push_back(1'b0);
        for (int n = 0; n < b.size(); n++) begin
            g0 = 1'b0;
            g1 = 1'b0;
            for (int d = 0; d < 3; d++) begin
                x = (n >= d) ? b[n-d] : 1'b0;
                if (g0p[2-d]) g0 ^= x;
                if (g1p[2-d]) g1 ^= x;
            end
            e.sym = {g0, g1};
            e.fs  = (n == 0);
            e.fe  = (n == b.size() - 1);
            syms.push_back(e);
        end
    endfunction

    // Error-free channel decoder: the single byte whose code word matches.
    function automatic int decode_byte(input int base);
        sym_t       r[$];
        logic [7:0] one[$];
        bit         ok;
        for (int v = 0; v < 256; v++) begin
            one = {8'(v)};
            encode(one, r);
            ok = rx_q.size() >= base + r.size();
            for (int i = 0; ok && i < r.size(); i++)
                if (rx_q[base+i].sym != r[i].sym) ok = 1'b0;
            if (ok) return v;
        end
        return -1;
    endfunction

    // Symbol capture, stall-stability and gap monitoring, sampled on the falling edge.
    logic       prev_stall = 1'b0;
    logic [1:0] prev_sym;
    logic       prev_start;

    always @(negedge clk) begin
        if (!reset) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                check_eq("stall_valid", 32'(obs_valid), 32'd1);
                check_eq("stall_sym", 32'(obs_sym), 32'(prev_sym));
                check_eq("stall_start", 32'(obs_start), 32'(prev_start));
            end
            if (obs_valid && out_ready) rx_q.push_back({obs_sym, obs_start, obs_end});
            if (obs_busy && !obs_valid) gap_cycles <= gap_cycles + 1;
            prev_stall <= obs_valid && !out_ready;
            prev_sym   <= obs_sym;
            prev_start <= obs_start;
        end
    end

    initial begin
        int cnt;
        cnt       = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            cnt++;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cnt % 4 == 0) || (cnt % 4 == 3);
                default: out_ready = ($urandom % 4) != 0;
            endcase
        end
    end

    task automatic drive_bytes(input logic [7:0] bytes[$], input int gaps[$]);
        int t;
        foreach (bytes[i]) begin
            if (gaps[i] > 0) begin
                in_valid = 1'b0;
                repeat (gaps[i]) @(posedge clk);
                #1;
            end
            in_data  = bytes[i];
            in_valid = 1'b1;
            t = 0;
            @(negedge clk);
            while (!obs_ready && t < 300) begin
                @(negedge clk);
                t++;
            end
            check_eq("byte_accepted", 32'(obs_ready), 32'd1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_syms(input int n);
        int t;
        t = 0;
        while (rx_q.size() < n && t < 2000) begin
            @(posedge clk);
            #1;
            t++;
        end
        check_eq("frame_complete", 32'(rx_q.size() >= n), 32'd1);
    endtask

    task automatic run_frame(input string tag, input logic sel_v, input logic [7:0] bytes[$],
                             input int gaps[$], output int base);
        sym_t a;
        base = rx_q.size();
        encode(bytes, exp_q);
        sel = sel_v;
        fork
            drive_bytes(bytes, gaps);
            wait_syms(base + exp_q.size());
        join
        for (int i = 0; i < exp_q.size(); i++) begin
            a = (base + i < rx_q.size()) ? rx_q[base+i] : 4'hx;
            check_eq($sformatf("%s sym%0d", tag, i), 32'(a), 32'(exp_q[i]));
        end
        @(posedge clk);
        #1;
        check_eq({tag, " idle_after"}, 32'(obs_busy), 32'd0);
    endtask

    task automatic check_table(input string tag, input int base, input int tab[$]);
        foreach (tab[i])
            check_eq($sformatf("%s tab%0d", tag, i),
                     32'((base + i < rx_q.size()) ? rx_q[base+i].sym : 2'bxx), 32'(tab[i]));
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, " in_ready"}, 32'(obs_ready), 32'd0);
        check_eq({tag, " out_valid"}, 32'(obs_valid), 32'd0);
        check_eq({tag, " out_sym"}, 32'(obs_sym), 32'd0);
        check_eq({tag, " frame_start"}, 32'(obs_start), 32'd0);
        check_eq({tag, " frame_end"}, 32'(obs_end), 32'd0);
        check_eq({tag, " busy"}, 32'(obs_busy), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] bq[$];
        int         gq[$];
        int         t1_tab[$];
        int         base, g_before, nb;

        t1_tab   = {3, 2, 3, 0, 0, 0, 0, 0, 0, 0};
        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        sel      = 1'b0;
        rdy_mode = 0;

        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_eq("idle in_ready", 32'(obs_ready), 32'd1);

        // 1: single byte 0x01
        bq = {8'h01};
        gq = {0};
        run_frame("t1", 1'b0, bq, gq, base);
        check_table("t1", base, t1_tab);
        check_eq("t1 decode", 32'(decode_byte(base)), 32'h01);

        // 2: all-ones byte, trellis must end in state 0
        bq = {8'hFF};
        run_frame("t2", 1'b0, bq, gq, base);
        check_table("t2", base, {3, 1, 2, 2, 2, 2, 2, 2, 1, 3});
        check_eq("t2 end_state", 32'(dut1.s_q), 32'd0);

        // 3: two bytes back-to-back, no output bubble
        bq = {8'h01, 8'h00};
        gq = {0, 0};
        g_before = gap_cycles;
        run_frame("t3", 1'b1, bq, gq, base);
        check_eq("t3 gaps", 32'(gap_cycles - g_before), 32'd0);

        // 4: output stalls in a 1,0,0,1 pattern
        rdy_mode = 1;
        bq = {8'h01};
        gq = {0};
        run_frame("t4", 1'b0, bq, gq, base);
        check_table("t4", base, t1_tab);
        rdy_mode = 0;

        // 5: second byte arrives five cycles late
        bq = {8'h01, 8'h00};
        gq = {0, 12};
        g_before = gap_cycles;
        run_frame("t5", 1'b1, bq, gq, base);
        check_eq("t5 gaps", 32'(gap_cycles - g_before), 32'd5);

        // 6: reset after the fourth symbol, then a clean frame
        sel = 1'b0;
        bq = {8'h01};
        gq = {0};
        base = rx_q.size();
        fork
            drive_bytes(bq, gq);
            wait_syms(base + 4);
        join
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check_outputs_zero("t6 abort");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        run_frame("t6", 1'b0, bq, gq, base);
        check_table("t6", base, t1_tab);
        check_eq("t6 decode", 32'(decode_byte(base)), 32'h01);

        // Random frames, random byte gaps and random output back-pressure
        rdy_mode = 2;
        for (int f = 0; f < 30; f++) begin
            nb = ($urandom % 2) + 1;
            bq = {};
            gq = {};
            for (int i = 0; i < nb; i++) begin
                bq.push_back(8'($urandom));
                gq.push_back(($urandom % 5 == 0) ? int'($urandom_range(1, 12)) : 0);
            end
            run_frame($sformatf("rnd%0d", f), nb == 2, bq, gq, base);
            if (nb == 1) check_eq($sformatf("rnd%0d decode", f), 32'(decode_byte(base)),
                                  32'(bq[0]));
        end
        rdy_mode = 0;

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
